// File: rtl/dmem_pkg.sv
// dmem_pkg: state encoding and counter width shared by the data-memory responder.
package dmem_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dmemState;
    localparam int cntWidth = 4;
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: memory-stage Rd/Wr request bus and responder status signals.
interface dmem_responder_if;
    logic        Rd;
    logic        Wr;
    logic [15:0] Addr;
    logic [15:0] DataIn;
    logic [15:0] DataOut;
    logic        Done;
    logic        Stall;
    logic        Err;
    modport master (output Rd, Wr, Addr, DataIn, input DataOut, Done, Stall, Err);
    modport slave (input Rd, Wr, Addr, DataIn, output DataOut, Done, Stall, Err);
endinterface

// File: rtl/dmem_array.sv
// dmem_array: 16-bit word storage with synchronous write and combinational read, never cleared.
module dmem_array #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [15:0]           wData,
    output logic [15:0]           rData
);
    logic [15:0] mem [2**DEPTH_LOG2];
    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wData;
    end
    assign rData = mem[idx];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store responder that stalls the memory stage for a
// fixed latency, then pulses Done with the load data.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input logic             clk,
    input logic             rst,
    dmem_responder_if.slave bus
);
    localparam logic [cntWidth-1:0] cntInit = cntWidth'(LATENCY - 1);
    dmemState              state;
    logic [cntWidth-1:0]   cnt;
    logic                  capWr;
    logic [DEPTH_LOG2-1:0] capIdx;
    logic [15:0]           capData;
    logic [DEPTH_LOG2-1:0] accIdx;
    logic [15:0]           accData;
    logic [15:0]           rData;
    logic [15:0]           dataOut;
    logic                  legal;
    logic                  accWr;
    logic                  enterDone;
    logic                  done;
    logic                  err;
    logic                  unusedAddr;
    // With LATENCY=1 the access happens on the accept edge, so IDLE uses the live request.
    always_comb begin
        legal     = (bus.Rd ^ bus.Wr) & ~bus.Addr[0];
        accWr     = (state == IDLE) ? bus.Wr : capWr;
        accIdx    = (state == IDLE) ? bus.Addr[DEPTH_LOG2:1] : capIdx;
        accData   = (state == IDLE) ? bus.DataIn : capData;
        enterDone = (state == IDLE) ? (legal && cntInit == '0)
                                    : (state == WAIT && cnt == cntWidth'(1));
    end
    dmem_array #(.DEPTH_LOG2(DEPTH_LOG2)) array (
        .clk   (clk),
        .we    (enterDone && accWr && rst),
        .idx   (accIdx),
        .wData (accData),
        .rData (rData)
    );
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            dataOut <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= enterDone;
            err  <= state == IDLE && (bus.Rd || bus.Wr) && !legal;
            if (enterDone && !accWr) dataOut <= rData;
            case (state)
                IDLE: if (legal) begin
                    capWr   <= bus.Wr;
                    capIdx  <= bus.Addr[DEPTH_LOG2:1];
                    capData <= bus.DataIn;
                    cnt     <= cntInit;
                    state   <= (cntInit == '0) ? DONE : WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == cntWidth'(1)) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign unusedAddr  = ^bus.Addr[15:DEPTH_LOG2+1];
    assign bus.Stall   = (state == IDLE && legal) || state == WAIT;
    assign bus.Done    = done;
    assign bus.Err     = err;
    assign bus.DataOut = dataOut;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and random load/store traffic against two responders
// (LATENCY 4 and 1), checked cycle by cycle against a word-array reference model.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int passed = 0;
    int failed = 0;
    logic [15:0] model [2][1024];
    bit known [2][1024];
    logic [15:0] expOut [2];
    bit outKnown [2];
    int lat [2] = '{4, 1};
    always #5 clk = ~clk;
    dmem_responder_if busA();
    dmem_responder_if busB();
    dmem_responder #(.DEPTH_LOG2(10), .LATENCY(4)) dutA (.clk(clk), .rst(rst), .bus(busA.slave));
    dmem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) dutB (.clk(clk), .rst(rst), .bus(busB.slave));
    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic drive(input int d, input logic r, input logic w, input logic [15:0] a,
                         input logic [15:0] dat);
        if (d == 0) begin
            busA.Rd = r; busA.Wr = w; busA.Addr = a; busA.DataIn = dat;
        end else begin
            busB.Rd = r; busB.Wr = w; busB.Addr = a; busB.DataIn = dat;
        end
    endtask
    // {Stall, Done, Err, DataOut}
    function automatic logic [18:0] sample(input int d);
        return d == 0 ? {busA.Stall, busA.Done, busA.Err, busA.DataOut}
                      : {busB.Stall, busB.Done, busB.Err, busB.DataOut};
    endfunction
    task automatic idleChk(input int d, input string tag);
        logic [18:0] s;
        s = sample(d);
        chk({tag, " stall"}, 16'(s[18]), 16'd0);
        chk({tag, " done"}, 16'(s[17]), 16'd0);
        chk({tag, " err"}, 16'(s[16]), 16'd0);
    endtask
    // Issues one request at the current cycle (cycle 0) and checks every cycle until it retires.
    task automatic req(input int d, input logic r, input logic w, input logic [15:0] a,
                       input logic [15:0] dat);
        logic [18:0] s;
        bit ok;
        int n;
        int idx;
        ok  = (r ^ w) && !a[0];
        n   = ok ? lat[d] : 1;
        idx = (int'(a) / 2) % 1024;
        drive(d, r, w, a, dat);
        for (int c = 0; c <= n; c++) begin
            @(negedge clk);
            s = sample(d);
            chk($sformatf("stall d%0d a%h c%0d", d, a, c), 16'(s[18]), 16'(ok && c < n));
            chk($sformatf("done d%0d a%h c%0d", d, a, c), 16'(s[17]), 16'(ok && c == n));
            chk($sformatf("err d%0d a%h c%0d", d, a, c), 16'(s[16]), 16'(!ok && c == 1));
            if (ok && c == n) begin
                if (w) begin
                    model[d][idx] = dat;
                    known[d][idx] = 1'b1;
                end else begin
                    expOut[d]   = model[d][idx];
                    outKnown[d] = known[d][idx];
                end
                if (outKnown[d]) chk($sformatf("data d%0d a%h", d, a), s[15:0], expOut[d]);
            end
            @(posedge clk);
            #1;
            if (c == 0 && !ok) drive(d, 1'b0, 1'b0, 16'h0, 16'h0);
        end
        drive(d, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask
    // Store on dutA with reset asserted during cycle rc; the store must be discarded.
    task automatic rstDuring(input logic [15:0] a, input logic [15:0] dat, input int rc);
        logic [18:0] s;
        drive(0, 1'b0, 1'b1, a, dat);
        for (int c = 0; c < rc; c++) begin
            @(negedge clk);
            chk($sformatf("rst stall c%0d", c), 16'(sample(0) >> 18), 16'd1);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        expOut[0] = 16'h0;
        expOut[1] = 16'h0;
        outKnown[0] = 1'b1;
        outKnown[1] = 1'b1;
        @(negedge clk);
        s = sample(0);
        idleChk(0, "post-rst");
        chk("post-rst data", s[15:0], 16'h0);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            idleChk(0, "post-rst quiet");
        end
        @(posedge clk);
        #1;
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        int k;
        logic [15:0] a;
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            idleChk(d, $sformatf("reset d%0d", d));
            chk($sformatf("reset data d%0d", d), sample(d) & 19'hFFFF, 19'h0);
            expOut[d] = 16'h0;
            outKnown[d] = 1'b1;
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        req(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF);
        req(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        req(0, 1'b0, 1'b1, 16'h0020, 16'h5A5A);
        req(0, 1'b1, 1'b1, 16'h0020, 16'hFFFF);
        req(0, 1'b1, 1'b0, 16'h0020, 16'h0000);
        req(0, 1'b1, 1'b0, 16'h0011, 16'h0000);
        req(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        req(0, 1'b0, 1'b1, 16'h0802, 16'h1234);
        req(0, 1'b1, 1'b0, 16'h0002, 16'h0000);
        req(0, 1'b0, 1'b1, 16'h0040, 16'h0F0F);
        rstDuring(16'h0040, 16'hAAAA, 2);
        req(0, 1'b1, 1'b0, 16'h0040, 16'h0000);
        rstDuring(16'h0040, 16'hCCCC, 3);
        req(0, 1'b1, 1'b0, 16'h0040, 16'h0000);
        req(1, 1'b1, 1'b0, 16'h0010, 16'h0000);
        req(1, 1'b0, 1'b1, 16'h0010, 16'h7777);
        req(1, 1'b1, 1'b0, 16'h0010, 16'h0000);
        req(1, 1'b0, 1'b1, 16'h0011, 16'h1111);
        for (int i = 0; i < 60; i++) begin
            k = int'($urandom_range(0, 7));
            a = 16'($urandom) & 16'h0C1E;
            if ($urandom_range(0, 7) == 0) a[0] = 1'b1;
            req(i % 3 == 0 ? 1 : 0, k == 0 || k[0], k == 0 || !k[0], a, 16'($urandom));
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
